// File: rtl/div_pkg.sv
// Shared definitions for the radix-2 restoring divider.
package div_pkg;
  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // 0x80000000 maps to itself, which reads correctly as unsigned 2^31.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift, trial subtract, select.
module div_step
  import div_pkg::*;
#(
  parameter int width = WIDTH
) (
  input  logic [width-1:0] rem,
  input  logic [width-1:0] quo,
  input  logic [width-1:0] dvs,
  output logic [width-1:0] rem_next,
  output logic [width-1:0] quo_next
);
  logic [width:0] shifted;
  logic [width:0] diff;

  // The extra top bit of diff is the borrow: set means the trial subtract went negative.
  assign shifted  = {rem, quo[width-1]};
  assign diff     = shifted - {1'b0, dvs};
  assign rem_next = diff[width] ? shifted[width-1:0] : diff[width-1:0];
  assign quo_next = {quo[width-2:0], ~diff[width]};
endmodule

// File: rtl/divider.sv
// Multi-cycle signed/unsigned 32-bit divider with divide-by-zero and overflow fast paths.
module divider
  import div_pkg::*;
#(
  parameter int width = WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [width-1:0] rs1_i,
  input  logic [width-1:0] rs2_i,
  output logic [width-1:0] quotient_o,
  output logic [width-1:0] remainder_o,
  output logic             busy,
  output logic             valid
);
  localparam logic [width-1:0] MIN_NEG = {1'b1, {(width-1){1'b0}}};

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [width-1:0] rem_reg;
  logic [width-1:0] quo_reg;
  logic [width-1:0] dvs_reg;
  logic             neg_q;
  logic             neg_r;
  logic [width-1:0] rem_next;
  logic [width-1:0] quo_next;
  logic             div_zero;
  logic             overflow;

  assign div_zero = (rs2_i == '0);
  assign overflow = signed_i && (rs1_i == MIN_NEG) && (rs2_i == '1);

  div_step #(.width(width)) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .dvs      (dvs_reg),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      count       <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      dvs_reg     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      busy        <= 1'b0;
      valid       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            busy    <= 1'b1;
            dvs_reg <= magnitude(rs2_i, signed_i);
            count   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            // Special cases preload the final result and let FIX publish it unsigned.
            if (div_zero) begin
              quo_reg <= '1;
              rem_reg <= rs1_i;
              state   <= FIX;
            end else if (overflow) begin
              quo_reg <= MIN_NEG;
              rem_reg <= '0;
              state   <= FIX;
            end else begin
              quo_reg <= magnitude(rs1_i, signed_i);
              rem_reg <= '0;
              neg_q   <= signed_i && (rs1_i[width-1] ^ rs2_i[width-1]);
              neg_r   <= signed_i && rs1_i[width-1];
              count   <= CNT_W'(width - 1);
              state   <= CALC;
            end
          end
        end
        CALC: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          if (count == '0) state <= FIX;
          else             count <= count - 1'b1;
        end
        FIX: begin
          quotient_o  <= neg_q ? -quo_reg : quo_reg;
          remainder_o <= neg_r ? -rem_reg : rem_reg;
          valid       <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divider.sv
// Directed and random checks of the divider against a scoreboard of expected results.
module tb_divider;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        valid;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          busy_cyc = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  always #5 clk = ~clk;

  divider #(.width(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .signed_i    (sgn),
    .rs1_i       (a),
    .rs2_i       (b),
    .quotient_o  (q),
    .remainder_o (r),
    .busy        (busy),
    .valid       (valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (busy) busy_cyc++;
    check("busy_valid_overlap", {31'b0, busy & valid}, 32'd0);
  endtask

  function automatic exp_t model(input logic s, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e.lat = 33;
    if (y == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = x; e.lat = 1;
    end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = 32'd0; e.lat = 1;
    end else if (s) begin
      e.q = $signed(x) / $signed(y);
      e.r = $signed(x) % $signed(y);
    end else begin
      e.q = x / y;
      e.r = x % y;
    end
    return e;
  endfunction

  task automatic launch(input logic s, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eq, input logic [31:0] er, input int elat,
                        input bit push);
    exp_t e;
    e.q = eq; e.r = er; e.lat = elat;
    sgn = s; a = x; b = y; start = 1'b1;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    busy_cyc = busy ? 1 : 0;
  endtask

  task automatic wait_result(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (!valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_valid_seen"}, {31'b0, valid}, 32'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_scoreboard observed empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      if (valid) begin
        check({tag, "_latency"}, cyc, e.lat);
        check({tag, "_busy_cycles"}, busy_cyc, e.lat);
        check({tag, "_busy_at_valid"}, {31'b0, busy}, 32'd0);
        check({tag, "_quotient"}, q, e.q);
        check({tag, "_remainder"}, r, e.r);
        last_q = e.q;
        last_r = e.r;
      end
    end
  endtask

  initial begin
    exp_t m;
    logic [31:0] x;
    logic [31:0] y;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_quotient", q, 32'd0);
    check("reset_remainder", r, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_valid", {31'b0, valid}, 32'd0);
    rst = 1'b0;
    tick();

    launch(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b1);
    wait_result("u100_7");
    // Launched in the valid cycle: exercises back-to-back acceptance.
    launch(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b1);
    wait_result("s_m7_2_b2b");
    tick();
    launch(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 33, 1'b1);
    wait_result("u_fff9_2");

    repeat (3) tick();
    check("hold_quotient", q, last_q);
    check("hold_remainder", r, last_r);
    check("hold_no_valid", {31'b0, valid}, 32'd0);

    launch(1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1, 1'b1);
    wait_result("u_div0");
    tick();
    launch(1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1, 1'b1);
    wait_result("s_div0");
    tick();
    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1, 1'b1);
    wait_result("s_overflow");
    tick();
    launch(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, 1'b1);
    wait_result("u_overflow_ops");

    tick();
    launch(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 33, 1'b1);
    repeat (5) tick();
    sgn = 1'b1; a = 32'd999; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_result("start_while_busy");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_queued_start", {31'b0, valid | busy}, 32'd0);
    end

    launch(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33, 1'b0);
    repeat (10) tick();
    rst = 1'b1;
    #1;
    check("abort_quotient", q, 32'd0);
    check("abort_remainder", r, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_valid", {31'b0, valid}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      check("abort_no_valid", {31'b0, valid}, 32'd0);
    end
    launch(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 33, 1'b1);
    wait_result("after_reset");

    for (int i = 0; i < 8; i++) begin
      x = $urandom;
      y = (i % 3 == 0) ? $urandom_range(1, 300) : $urandom;
      if (i == 5) y = 32'hFFFF_FFFF;
      m = model(i[0], x, y);
      launch(i[0], x, y, m.q, m.r, m.lat, 1'b1);
      wait_result("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter: width, 32, operand width in bits; only 32 is supported.
REQ-002 SHALL have port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start_i  input  1  request a division; sampled at a rising edge only while idle.
REQ-005 SHALL have port: signed_i  input  1  1 = two's-complement operands, 0 = unsigned; captured with start_i.
REQ-006 SHALL have port: rs1_i  input  width  dividend; captured with start_i.
REQ-007 SHALL have port: rs2_i  input  width  divisor; captured with start_i.
REQ-008 SHALL have port: quotient_o  output  width  registered quotient.
REQ-009 SHALL have port: remainder_o  output  width  registered remainder.
REQ-010 SHALL have port: busy  output  1  high while a division is in progress.
REQ-011 SHALL have port: valid  output  1  one-cycle pulse marking a new result on quotient_o/remainder_o.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and FIX; the reset state is IDLE.
REQ-013 In IDLE with start_i=1 at edge E0: capture the operands, convert them to magnitudes when signed_i=1, record the quotient and remainder signs, load an iteration counter of 31, and go to CALC.
REQ-014 CALC SHALL perform one radix-2 restoring step per cycle (shift the partial remainder left, subtract the divisor magnitude, keep the result if non-negative, shift in one quotient bit) for exactly 32 cycles at edges E1..E32, then go to FIX.
REQ-015 FIX, at edge E33, SHALL apply signs: negate the quotient if the operand signs differ; give the remainder the sign of the dividend.
REQ-016 FIX SHALL register quotient_o/remainder_o, pulse valid=1 for one cycle, and return to IDLE.
REQ-017 Normal latency SHALL be 33 cycles: valid is high in the cycle after edge E33.
REQ-018 busy SHALL be high from after E0 until valid is high; busy and valid SHALL never be high together.
REQ-019 start_i SHALL be ignored while busy=1; no queuing.
REQ-020 A start_i sampled in the cycle where valid=1 SHALL be accepted, giving back-to-back operation.
REQ-021 quotient_o/remainder_o SHALL hold their last value until the next valid pulse.
REQ-022 Divide by zero (rs2_i=0, either mode) SHALL skip CALC and go IDLE->FIX, setting quotient=all ones and remainder=rs1_i; valid follows at E1.
REQ-023 Signed overflow (rs1_i=0x80000000, rs2_i=0xFFFFFFFF, signed_i=1) SHALL skip CALC, setting quotient=0x80000000 and remainder=0; valid follows at E1.
REQ-024 Internal partial-remainder arithmetic SHALL be width+1 bits wide so the subtract borrow is visible; the magnitude of 0x80000000 SHALL be handled as unsigned 2^31.

Reset
REQ-025 While rst_i is high, asynchronously: state=IDLE, counter=0, quotient_o=0, remainder_o=0, busy=0, valid=0; all internal operand registers=0.
REQ-026 Reset during CALC or FIX SHALL abort the operation with no valid pulse; the first start_i after rst_i deasserts SHALL be accepted normally.

Structure
REQ-027 The FSM state encoding and the width constant SHALL reside in shared package div_pkg.
REQ-028 One combinational sub-module div_step SHALL implement a single shift/subtract/select iteration; divider instantiates it once.

Verification
REQ-029 Unsigned: rs1=100, rs2=7 -> quotient=14, remainder=2; valid exactly 33 cycles after the start edge; busy high for 33 cycles.
REQ-030 Signed: rs1=0xFFFFFFF9 (-7), rs2=2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; unsigned 0xFFFFFFF9/2 -> quotient=0x7FFFFFFC, remainder=1.
REQ-031 Divide by zero: rs1=0x00001234, rs2=0 -> quotient=0xFFFFFFFF, remainder=0x00001234; valid one cycle after E1.
REQ-032 Overflow: signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, short latency; unsigned same operands -> quotient=0, remainder=0x80000000.
REQ-033 Protocol: start_i pulsed while busy -> ignored, result unchanged; start_i in the valid cycle -> second result 33 cycles later.
REQ-034 Reset: rst_i asserted at CALC cycle 10 -> outputs 0, busy 0, no valid; then 1000/10 -> quotient=100, remainder=0.
